mul_accum: RTL and testbench

//  Sequential accumulator stage directly downstream of the signed combinational multiplier.

---
 rtl/mul_accum.sv | 111 +++++++++++
 tb/tb_mul_accum.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul_accum
// Summary  : Signed multiply-accumulate stage that sums COUNT sign-extended
//            products and holds each result behind a valid/ready handshake.
//            The ACC_SAT_EN macro selects saturating arithmetic (default wrap).
// Revision : 1.0  initial release
// ============================================================================
module mul_accum #(
    parameter int WIDTH     = 6,
    parameter int COUNT     = 4,
    parameter int ACC_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [2*WIDTH-1:0]     prod_in,
    input  logic                   prod_valid,
    output logic                   prod_ready,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   acc_valid,
    input  logic                   acc_ready,
    output logic [7:0]             acc_cnt,
    output logic                   acc_ovf
);

    localparam int                   C_PROD_W = 2 * WIDTH;
    localparam logic [7:0]           C_COUNT  = 8'(COUNT);
    localparam logic [ACC_WIDTH-1:0] C_MAX    = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] C_MIN    = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                 r_state;
    logic [ACC_WIDTH:0]     w_ext;
    logic [ACC_WIDTH:0]     w_wide;
    logic                   w_ovf;
    logic [ACC_WIDTH-1:0]   w_next_sum;
    logic                   w_accept;
    logic [7:0]             w_cnt_inc;

    // One guard bit above the accumulator exposes signed overflow.
    assign w_ext     = {{(ACC_WIDTH+1-C_PROD_W){prod_in[C_PROD_W-1]}}, prod_in};
    assign w_wide    = {acc_out[ACC_WIDTH-1], acc_out} + w_ext;
    assign w_ovf     = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];
    assign w_accept  = prod_valid & prod_ready;
    assign w_cnt_inc = acc_cnt + 8'd1;

`ifdef ACC_SAT_EN
    // The guard bit carries the true sign, so it picks the clamp direction.
    assign w_next_sum = w_ovf ? (w_wide[ACC_WIDTH] ? C_MIN : C_MAX)
                              : w_wide[ACC_WIDTH-1:0];
`else
    assign w_next_sum = w_wide[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state    <= S_IDLE;
            acc_out    <= '0;
            acc_cnt    <= '0;
            acc_ovf    <= 1'b0;
            acc_valid  <= 1'b0;
            prod_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_accept) begin
                        acc_out <= w_next_sum;
                        acc_cnt <= w_cnt_inc;
                        if (w_ovf) begin
                            acc_ovf <= 1'b1;
                        end
                        if (w_cnt_inc == C_COUNT) begin
                            r_state    <= S_HOLD;
                            acc_valid  <= 1'b1;
                            prod_ready <= 1'b0;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_HOLD: begin
                    if (acc_ready) begin
                        r_state    <= S_IDLE;
                        acc_out    <= '0;
                        acc_cnt    <= '0;
                        acc_ovf    <= 1'b0;
                        acc_valid  <= 1'b0;
                        prod_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    acc_out    <= '0;
                    acc_cnt    <= '0;
                    acc_ovf    <= 1'b0;
                    acc_valid  <= 1'b0;
                    prod_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mul_accum
// Summary  : Directed scoreboard bench for mul_accum (16-bit and 12-bit
//            accumulator instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        clear_b = 1'b0;

    logic [11:0] prod_a = '0;
    logic        pvalid_a = 1'b0;
    logic        aready_a = 1'b0;
    logic        pready_a;
    logic [15:0] out_a;
    logic        valid_a;
    logic [7:0]  cnt_a;
    logic        ovf_a;

    logic [11:0] prod_b = '0;
    logic        pvalid_b = 1'b0;
    logic        aready_b = 1'b0;
    logic        pready_b;
    logic [11:0] out_b;
    logic        valid_b;
    logic [7:0]  cnt_b;
    logic        ovf_b;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_a[$];
    logic [12:0] exp_b[$];

    always #5 clk = ~clk;

    mul_accum dut_a (
        .clk(clk), .rst(rst), .clear(clear),
        .prod_in(prod_a), .prod_valid(pvalid_a), .prod_ready(pready_a),
        .acc_out(out_a), .acc_valid(valid_a), .acc_ready(aready_a),
        .acc_cnt(cnt_a), .acc_ovf(ovf_a)
    );

    mul_accum #(.ACC_WIDTH(12)) dut_b (
        .clk(clk), .rst(rst), .clear(clear_b),
        .prod_in(prod_b), .prod_valid(pvalid_b), .prod_ready(pready_b),
        .acc_out(out_b), .acc_valid(valid_b), .acc_ready(aready_b),
        .acc_cnt(cnt_b), .acc_ovf(ovf_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Result monitors: pop the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (!rst && valid_a && aready_a) begin
            if (exp_a.size() == 0) begin
                flag("a unexpected result");
            end else begin
                logic [16:0] e;
                e = exp_a.pop_front();
                check("a result", 32'(out_a), 32'(e[15:0]));
                check("a ovf", 32'(ovf_a), 32'(e[16]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid_b && aready_b) begin
            if (exp_b.size() == 0) begin
                flag("b unexpected result");
            end else begin
                logic [12:0] e;
                e = exp_b.pop_front();
                check("b result", 32'(out_b), 32'(e[11:0]));
                check("b ovf", 32'(ovf_b), 32'(e[12]));
            end
        end
    end

    task automatic put_a(input logic [11:0] p);
        prod_a = p;
        pvalid_a = 1'b1;
        @(posedge clk); #1;
        pvalid_a = 1'b0;
    endtask

    task automatic put_b(input logic [11:0] p);
        prod_b = p;
        pvalid_b = 1'b1;
        @(posedge clk); #1;
        pvalid_b = 1'b0;
    endtask

    task automatic drain_a();
        aready_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!valid_a) break;
        end
        if (valid_a) flag("a drain timeout");
        aready_a = 1'b0;
    endtask

    task automatic drain_b();
        aready_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!valid_b) break;
        end
        if (valid_b) flag("b drain timeout");
        aready_b = 1'b0;
    endtask

    task automatic burst_a();
        put_a(12'h00A);
        put_a(12'hFFD);
        put_a(12'h064);
        put_a(12'hC20);
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("reset out", 32'(out_a), 32'h0);
        check("reset valid", 32'(valid_a), 32'h0);
        check("reset cnt", 32'(cnt_a), 32'h0);
        check("reset ovf", 32'(ovf_a), 32'h0);
        check("reset prod_ready", 32'(pready_a), 32'h1);
        check("reset b prod_ready", 32'(pready_b), 32'h1);

        // Basic sum: 10 - 3 + 100 - 992 = -885
        burst_a();
        check("sum valid", 32'(valid_a), 32'h1);
        check("sum value", 32'(out_a), 32'hFC8B);
        check("sum cnt", 32'(cnt_a), 32'h4);
        check("sum prod_ready", 32'(pready_a), 32'h0);
        exp_a.push_back({1'b0, 16'hFC8B});
        drain_a();
        check("post-hs out", 32'(out_a), 32'h0);
        check("post-hs cnt", 32'(cnt_a), 32'h0);
        check("post-hs prod_ready", 32'(pready_a), 32'h1);

        // Back-pressure: held result is stable, offered products ignored
        burst_a();
        exp_a.push_back({1'b0, 16'hFC8B});
        prod_a = 12'h111;
        pvalid_a = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("hold valid", 32'(valid_a), 32'h1);
            check("hold out", 32'(out_a), 32'hFC8B);
            check("hold prod_ready", 32'(pready_a), 32'h0);
            check("hold cnt", 32'(cnt_a), 32'h4);
        end
        pvalid_a = 1'b0;
        drain_a();
        put_a(12'h001);
        put_a(12'h002);
        put_a(12'h003);
        put_a(12'h004);
        check("fresh sum", 32'(out_a), 32'h000A);
        exp_a.push_back({1'b0, 16'h000A});
        drain_a();

        // Clear drops a partial sum and a same-cycle product
        put_a(12'h005);
        put_a(12'h007);
        check("partial cnt", 32'(cnt_a), 32'h2);
        check("partial out", 32'(out_a), 32'h000C);
        clear = 1'b1;
        prod_a = 12'h100;
        pvalid_a = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        pvalid_a = 1'b0;
        check("clear cnt", 32'(cnt_a), 32'h0);
        check("clear out", 32'(out_a), 32'h0);
        check("clear prod_ready", 32'(pready_a), 32'h1);
        repeat (4) put_a(12'h001);
        exp_a.push_back({1'b0, 16'h0004});
        drain_a();

        // 12-bit accumulator overflow
        put_b(12'h400);
        put_b(12'h400);
        check("b ovf sticky", 32'(ovf_b), 32'h1);
`ifdef ACC_SAT_EN
        check("b mid clamp", 32'(out_b), 32'h7FF);
`else
        check("b mid wrap", 32'(out_b), 32'h800);
`endif
        put_b(12'h400);
        put_b(12'h400);
`ifdef ACC_SAT_EN
        exp_b.push_back({1'b1, 12'h7FF});
`else
        exp_b.push_back({1'b1, 12'h000});
`endif
        drain_b();
        check("b ovf after hs", 32'(ovf_b), 32'h0);
        check("b out after hs", 32'(out_b), 32'h0);

        // Reset while holding discards the result
        burst_a();
        check("pre-rst valid", 32'(valid_a), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst-hold valid", 32'(valid_a), 32'h0);
        check("rst-hold out", 32'(out_a), 32'h0);
        check("rst-hold prod_ready", 32'(pready_a), 32'h1);
        check("rst-hold cnt", 32'(cnt_a), 32'h0);

        repeat (2) @(posedge clk); #1;
        check("a queue empty", 32'(exp_a.size()), 32'h0);
        check("b queue empty", 32'(exp_b.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
